// File: rtl/axil_up_bridge.sv
// AXI4-Lite slave to up-bus initiator bridge. Independent write and read
// channels, each turning one AXI transaction into one up-bus request with an ack timeout.
module axil_up_bridge #(
    parameter int ADDRESS_WIDTH  = 14,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     up_clk,
    input  logic                     up_rst,

    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [ADDRESS_WIDTH+1:0] s_axi_awaddr,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    output logic [1:0]               s_axi_bresp,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    input  logic [ADDRESS_WIDTH+1:0] s_axi_araddr,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,

    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack
);

    localparam int          AW          = ADDRESS_WIDTH - 1;
    localparam logic [15:0] TIMEOUT_V   = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] DEAD_DATA   = 32'hDEAD_BEEF;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_WAIT = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_WAIT = 2'd2;
    localparam logic [1:0] R_RESP = 2'd3;

    function automatic logic strobe_full(input logic [3:0] strb);
        return (strb == 4'hF);
    endfunction

    logic [1:0]    w_state_r;
    logic          awready_r;
    logic          wready_r;
    logic          aw_held_r;
    logic          w_held_r;
    logic [3:0]    wstrb_r;
    logic [15:0]   w_cnt_r;
    logic          bvalid_r;
    logic [1:0]    bresp_r;
    logic          up_wreq_r;
    logic [AW:0]   up_waddr_r;
    logic [31:0]   up_wdata_r;

    logic [1:0]    r_state_r;
    logic          arready_r;
    logic [15:0]   r_cnt_r;
    logic          rvalid_r;
    logic [1:0]    rresp_r;
    logic [31:0]   rdata_r;
    logic          up_rreq_r;
    logic [AW:0]   up_raddr_r;

    logic          aw_hs_s;
    logic          w_hs_s;
    logic          aw_got_s;
    logic          w_got_s;
    logic [3:0]    wstrb_s;
    logic          ar_hs_s;
    logic          unused_addr_s;

    assign aw_hs_s  = s_axi_awvalid & awready_r;
    assign w_hs_s   = s_axi_wvalid & wready_r;
    assign aw_got_s = aw_held_r | aw_hs_s;
    assign w_got_s  = w_held_r | w_hs_s;
    // Strobe check must see the live wstrb when W completes on the same edge as AW.
    assign wstrb_s  = w_hs_s ? s_axi_wstrb : wstrb_r;
    assign ar_hs_s  = s_axi_arvalid & arready_r;

    assign unused_addr_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write channel: collect AW and W in any order, issue one up_wreq, await ack or timeout.
    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            w_state_r  <= W_IDLE;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            wstrb_r    <= 4'h0;
            w_cnt_r    <= 16'd0;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
            up_wreq_r  <= 1'b0;
            up_waddr_r <= '0;
            up_wdata_r <= 32'h0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        up_waddr_r <= s_axi_awaddr[AW+2:2];
                    end
                    if (w_hs_s) begin
                        up_wdata_r <= s_axi_wdata;
                        wstrb_r    <= s_axi_wstrb;
                    end
                    if (aw_got_s && w_got_s) begin
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        if (strobe_full(wstrb_s)) begin
                            w_state_r <= W_REQ;
                            up_wreq_r <= 1'b1;
                        end else begin
                            w_state_r <= W_RESP;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= RESP_SLVERR;
                        end
                    end else begin
                        aw_held_r <= aw_got_s;
                        w_held_r  <= w_got_s;
                        awready_r <= ~aw_got_s;
                        wready_r  <= ~w_got_s;
                    end
                end
                W_REQ: begin
                    up_wreq_r <= 1'b0;
                    w_cnt_r   <= 16'd0;
                    if (up_wack) begin
                        w_state_r <= W_RESP;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= RESP_OKAY;
                    end else begin
                        w_state_r <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (up_wack) begin
                        w_state_r <= W_RESP;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= RESP_OKAY;
                    end else if (w_cnt_r == TIMEOUT_V) begin
                        w_state_r <= W_RESP;
                        bvalid_r  <= 1'b1;
                        bresp_r   <= RESP_SLVERR;
                    end else begin
                        w_cnt_r <= w_cnt_r + 16'd1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_r <= W_IDLE;
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    bvalid_r  <= 1'b0;
                    up_wreq_r <= 1'b0;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel: one up_rreq per AR, capture rdata on ack or substitute on timeout.
    always_ff @(posedge up_clk or posedge up_rst) begin
        if (up_rst) begin
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b0;
            r_cnt_r    <= 16'd0;
            rvalid_r   <= 1'b0;
            rresp_r    <= RESP_OKAY;
            rdata_r    <= 32'h0;
            up_rreq_r  <= 1'b0;
            up_raddr_r <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_state_r  <= R_REQ;
                        arready_r  <= 1'b0;
                        up_rreq_r  <= 1'b1;
                        up_raddr_r <= s_axi_araddr[AW+2:2];
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                R_REQ: begin
                    up_rreq_r <= 1'b0;
                    r_cnt_r   <= 16'd0;
                    if (up_rack) begin
                        r_state_r <= R_RESP;
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_OKAY;
                        rdata_r   <= up_rdata;
                    end else begin
                        r_state_r <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (up_rack) begin
                        r_state_r <= R_RESP;
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_OKAY;
                        rdata_r   <= up_rdata;
                    end else if (r_cnt_r == TIMEOUT_V) begin
                        r_state_r <= R_RESP;
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_SLVERR;
                        rdata_r   <= DEAD_DATA;
                    end else begin
                        r_cnt_r <= r_cnt_r + 16'd1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_state_r <= R_IDLE;
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    rvalid_r  <= 1'b0;
                    up_rreq_r <= 1'b0;
                    arready_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_axi_awready = awready_r;
    assign s_axi_wready  = wready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;
    assign up_wreq       = up_wreq_r;
    assign up_waddr      = up_waddr_r;
    assign up_wdata      = up_wdata_r;
    assign up_rreq       = up_rreq_r;
    assign up_raddr      = up_raddr_r;

endmodule

// File: tb/tb_axil_up_bridge.sv
// Bench for axil_up_bridge: vector table plus corner sequences, with an up-bus
// responder model and response scoreboards for the B and R channels.
module tb_axil_up_bridge;

    logic        up_clk = 1'b0;
    logic        up_rst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [15:0] s_axi_awaddr;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [15:0] s_axi_araddr;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        up_wreq, up_wack, up_rreq, up_rack;
    logic [13:0] up_waddr, up_raddr;
    logic [31:0] up_wdata, up_rdata;

    axil_up_bridge #(.ADDRESS_WIDTH(14), .TIMEOUT_CYCLES(8)) dut (
        .up_clk(up_clk), .up_rst(up_rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
    );

    always #5 up_clk = ~up_clk;

    // Responder modes: 0 = registered ack one cycle after req, 1 = never ack, 2 = ack in req cycle.
    int          resp_mode = 0;
    logic        late_rack = 1'b0;
    logic [31:0] rd_value  = 32'h0;
    logic        wack_r    = 1'b0;
    logic        rack_r    = 1'b0;

    int          cyc = 0;
    int          wreq_cnt = 0, rreq_cnt = 0, wreq_cyc = 0, rreq_cyc = 0;
    logic [13:0] wreq_addr = 14'h0, rreq_addr = 14'h0;
    logic [31:0] wreq_data = 32'h0;

    assign up_wack  = wack_r | (up_wreq && resp_mode == 2);
    assign up_rack  = rack_r | (up_rreq && resp_mode == 2) | late_rack;
    assign up_rdata = rd_value;

    // Peripheral model and up-bus request monitor.
    always @(posedge up_clk) begin
        cyc    <= cyc + 1;
        wack_r <= up_wreq && (resp_mode == 0);
        rack_r <= up_rreq && (resp_mode == 0);
        if (up_wreq) begin
            wreq_cnt  <= wreq_cnt + 1;
            wreq_addr <= up_waddr;
            wreq_data <= up_wdata;
            wreq_cyc  <= cyc;
        end
        if (up_rreq) begin
            rreq_cnt  <= rreq_cnt + 1;
            rreq_addr <= up_raddr;
            rreq_cyc  <= cyc;
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        logic [13:0] exp_addr;
        int          exp_lat;
        int          exp_reqs;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [1:0] resp);
        exp_t e;
        e.resp = resp;
        e.data = 32'h0;
        wq.push_back(e);
    endtask

    task automatic push_r(input logic [1:0] resp, input logic [31:0] data);
        exp_t e;
        e.resp = resp;
        e.data = data;
        rq.push_back(e);
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, output int hs_cyc);
        int   n;
        logic aw_done, w_done, aw_hs, w_hs;
        aw_done = 1'b0; w_done = 1'b0; n = 0; hs_cyc = 0;
        @(posedge up_clk); #1;
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_awaddr = addr;
        if (w_lead == 0) s_axi_awvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge up_clk);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            if (aw_hs || w_hs) hs_cyc = cyc;
            @(posedge up_clk); #1;
            if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1'b1;  s_axi_wvalid = 1'b0; end
            n++;
            if (n == w_lead && !aw_done) s_axi_awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", 32'(n), 32'd0);
    endtask

    task automatic axi_read(input logic [15:0] addr, output int hs_cyc);
        int   n;
        logic hs;
        n = 0; hs = 1'b0; hs_cyc = 0;
        @(posedge up_clk); #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = addr;
        while (!hs && n < 50) begin
            @(negedge up_clk);
            hs = s_axi_arvalid && s_axi_arready;
            hs_cyc = cyc;
            @(posedge up_clk); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) check("ar_handshake_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_b(input int hold, output int b_cyc);
        logic       seen;
        logic [1:0] first;
        exp_t       e;
        int         n;
        seen = 1'b0; first = 2'b00; n = 0; b_cyc = 0;
        while (n < 100) begin
            @(negedge up_clk);
            if (s_axi_bvalid) begin
                if (!seen) begin seen = 1'b1; b_cyc = cyc; first = s_axi_bresp; end
                if (s_axi_bready) begin
                    check("bresp_stable", 32'(s_axi_bresp), 32'(first));
                    if (wq.size() == 0) check("b_unexpected", 32'(wq.size()), 32'd1);
                    else begin
                        e = wq.pop_front();
                        check("bresp", 32'(s_axi_bresp), 32'(e.resp));
                    end
                    @(posedge up_clk); #1;
                    s_axi_bready = 1'b0;
                    return;
                end
            end
            @(posedge up_clk); #1;
            if (seen && (cyc - b_cyc) >= hold) s_axi_bready = 1'b1;
            n++;
        end
        check("b_response_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_r(input int hold, output int r_cyc);
        logic        seen;
        logic [1:0]  first;
        logic [31:0] first_d;
        exp_t        e;
        int          n;
        seen = 1'b0; first = 2'b00; first_d = 32'h0; n = 0; r_cyc = 0;
        while (n < 100) begin
            @(negedge up_clk);
            if (s_axi_rvalid) begin
                if (!seen) begin seen = 1'b1; r_cyc = cyc; first = s_axi_rresp; first_d = s_axi_rdata; end
                if (s_axi_rready) begin
                    check("rresp_stable", 32'(s_axi_rresp), 32'(first));
                    check("rdata_stable", s_axi_rdata, first_d);
                    if (rq.size() == 0) check("r_unexpected", 32'(rq.size()), 32'd1);
                    else begin
                        e = rq.pop_front();
                        check("rresp", 32'(s_axi_rresp), 32'(e.resp));
                        check("rdata", s_axi_rdata, e.data);
                    end
                    @(posedge up_clk); #1;
                    s_axi_rready = 1'b0;
                    return;
                end
            end
            @(posedge up_clk); #1;
            if (seen && (cyc - r_cyc) >= hold) s_axi_rready = 1'b1;
            n++;
        end
        check("r_response_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   hs, rc, n0, n1, hs_w, bc_w, hs_r, rc_r;
        logic seen;

        vecs[0] = vec_t'{1'b1, 16'h0010, 32'h1234_5678, 4'hF, 0, 2'b00, 32'h0,         14'h0004, 3,  1};
        vecs[1] = vec_t'{1'b0, 16'h0008, 32'hCAFE_0001, 4'hF, 0, 2'b00, 32'hCAFE_0001, 14'h0002, 3,  1};
        vecs[2] = vec_t'{1'b0, 16'h0020, 32'h1111_2222, 4'hF, 1, 2'b10, 32'hDEAD_BEEF, 14'h0008, 11, 1};
        vecs[3] = vec_t'{1'b1, 16'h0020, 32'h3333_4444, 4'h3, 0, 2'b10, 32'h0,         14'h0008, 1,  0};
        vecs[4] = vec_t'{1'b1, 16'hFFFC, 32'hA5A5_5A5A, 4'hF, 2, 2'b00, 32'h0,         14'h3FFF, 2,  1};
        vecs[5] = vec_t'{1'b1, 16'h0104, 32'h0F0F_0F0F, 4'hF, 1, 2'b10, 32'h0,         14'h0041, 11, 1};
        vecs[6] = vec_t'{1'b0, 16'h0007, 32'h0BAD_F00D, 4'hF, 2, 2'b00, 32'h0BAD_F00D, 14'h0001, 2,  1};
        vecs[7] = vec_t'{1'b0, 16'hFFFF, 32'h600D_CAFE, 4'hF, 0, 2'b00, 32'h600D_CAFE, 14'h3FFF, 3,  1};

        up_rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 16'h0; s_axi_wvalid = 1'b0; s_axi_wdata = 32'h0;
        s_axi_wstrb = 4'h0; s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = 16'h0;
        s_axi_rready = 1'b0;
        repeat (3) @(posedge up_clk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_wreq_rreq", 32'({up_wreq, up_rreq}), 32'd0);
        check("rst_rdata",   s_axi_rdata, 32'h0);
        check("rst_waddr",   32'(up_waddr), 32'd0);
        up_rst = 1'b0;
        @(posedge up_clk); #1;
        check("release_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            resp_mode = v.mode;
            rd_value  = v.data;
            if (v.wr) begin
                n0 = wreq_cnt;
                push_w(v.exp_resp);
                axi_write(v.addr, v.data, v.strb, 0, hs);
                wait_b(0, rc);
                check($sformatf("v%0d_b_latency", i), 32'(rc - hs), 32'(v.exp_lat));
                check($sformatf("v%0d_wreq_count", i), 32'(wreq_cnt - n0), 32'(v.exp_reqs));
                if (v.exp_reqs != 0) begin
                    check($sformatf("v%0d_waddr", i), 32'(wreq_addr), 32'(v.exp_addr));
                    check($sformatf("v%0d_wdata", i), wreq_data, v.data);
                    check($sformatf("v%0d_wreq_cycle", i), 32'(wreq_cyc - hs), 32'd1);
                end
            end else begin
                n0 = rreq_cnt;
                push_r(v.exp_resp, v.exp_data);
                axi_read(v.addr, hs);
                wait_r(0, rc);
                check($sformatf("v%0d_r_latency", i), 32'(rc - hs), 32'(v.exp_lat));
                check($sformatf("v%0d_rreq_count", i), 32'(rreq_cnt - n0), 32'(v.exp_reqs));
                check($sformatf("v%0d_raddr", i), 32'(rreq_addr), 32'(v.exp_addr));
                check($sformatf("v%0d_rreq_cycle", i), 32'(rreq_cyc - hs), 32'd1);
            end
        end

        // W five cycles ahead of AW, bready held off for several cycles.
        resp_mode = 0;
        n0 = wreq_cnt;
        push_w(2'b00);
        axi_write(16'h0044, 32'hABCD_0123, 4'hF, 5, hs);
        wait_b(4, rc);
        check("wfirst_wreq_count", 32'(wreq_cnt - n0), 32'd1);
        check("wfirst_waddr", 32'(wreq_addr), 32'h0011);
        check("wfirst_wdata", wreq_data, 32'hABCD_0123);
        check("wfirst_b_latency", 32'(rc - hs), 32'd3);

        // Read timeout with delayed rready, then a late ack that must be ignored.
        resp_mode = 1;
        n0 = rreq_cnt;
        push_r(2'b10, 32'hDEAD_BEEF);
        axi_read(16'h0100, hs);
        wait_r(3, rc);
        check("timeout_r_latency", 32'(rc - hs), 32'd11);
        late_rack = 1'b1;
        @(posedge up_clk); #1;
        late_rack = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge up_clk);
            if (s_axi_rvalid) seen = 1'b1;
        end
        check("late_rack_ignored", 32'(seen), 32'd0);
        check("late_rack_rreq_count", 32'(rreq_cnt - n0), 32'd1);

        // Bad-strobe write concurrent with a normal read.
        resp_mode = 0;
        rd_value  = 32'h7777_0001;
        n0 = wreq_cnt;
        n1 = rreq_cnt;
        push_w(2'b10);
        push_r(2'b00, 32'h7777_0001);
        fork
            begin
                axi_write(16'h0050, 32'h0000_0001, 4'h3, 0, hs_w);
                wait_b(0, bc_w);
            end
            begin
                axi_read(16'h0054, hs_r);
                wait_r(0, rc_r);
            end
        join
        check("conc_wreq_count", 32'(wreq_cnt - n0), 32'd0);
        check("conc_rreq_count", 32'(rreq_cnt - n1), 32'd1);
        check("conc_raddr", 32'(rreq_addr), 32'h0015);
        check("conc_r_latency", 32'(rc_r - hs_r), 32'd3);

        // Reset while the write channel waits for an ack.
        resp_mode = 1;
        axi_write(16'h0030, 32'h5555_AAAA, 4'hF, 0, hs);
        repeat (3) @(posedge up_clk);
        #1;
        up_rst = 1'b1;
        #1;
        check("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("midrst_awready", 32'(s_axi_awready), 32'd0);
        check("midrst_waddr", 32'(up_waddr), 32'd0);
        @(posedge up_clk); #1;
        up_rst = 1'b0;
        @(posedge up_clk); #1;
        check("midrst_release_awready", 32'(s_axi_awready), 32'd1);
        seen = 1'b0;
        repeat (15) begin
            @(negedge up_clk);
            if (s_axi_bvalid) seen = 1'b1;
        end
        check("midrst_no_response", 32'(seen), 32'd0);
        resp_mode = 0;
        n0 = wreq_cnt;
        push_w(2'b00);
        axi_write(16'h0034, 32'h0102_0304, 4'hF, 0, hs);
        wait_b(0, rc);
        check("postrst_b_latency", 32'(rc - hs), 32'd3);
        check("postrst_waddr", 32'(wreq_addr), 32'h000D);
        check("postrst_wreq_count", 32'(wreq_cnt - n0), 32'd1);
        check("scoreboards_drained", 32'(wq.size() + rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
